// File: rtl/decim_fir_core.sv
// Polyphase decimating FIR engine: pulls samples from an upstream FIFO,
// keeps them in a circular delay line and, once per DECIM inputs, runs a
// sequential TAPS-long multiply-accumulate against a loadable coefficient
// RAM, emitting one saturated output sample.
//
// state | meaning
// CLEAR | zero the delay line one entry per cycle; hold here while init=1
// IDLE  | wait for en & !rempty, then strobe rinc
// WAIT  | FIFO data valid: store it, advance the phase
// CALC  | issue one delay-line/coefficient read pair per cycle
// DRAIN | let the read/multiply pipeline empty into the accumulator
// OUT   | output register and valid pulse are live for this cycle
module decim_fir_core #(
    parameter int DATA_WIDTH = 32,
    parameter int DECIM      = 4,
    parameter int TAPS       = 32,
    parameter int TAP_AW     = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  init,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    output logic                  rinc,
    input  logic                  coe_we,
    input  logic [TAP_AW-1:0]     coe_addr,
    input  logic [DATA_WIDTH-1:0] coe_init,
    output logic                  out_sample_valid,
    output logic [DATA_WIDTH-1:0] out_sample,
    output logic                  busy,
    output logic                  error_code
);

    localparam int PW  = 2 * DATA_WIDTH;
    localparam int AW  = 2 * DATA_WIDTH + TAP_AW;
    localparam int PHW = (DECIM > 2) ? $clog2(DECIM) : 1;

    // Saturation bounds expressed at accumulator width after the Q-format shift.
    localparam logic signed [AW-1:0] SAT_MAX = {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [AW-1:0] SAT_MIN = {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_CLEAR,
        S_IDLE,
        S_WAIT,
        S_CALC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t                  r_state;
    logic [TAP_AW-1:0]       r_clr_cnt;
    logic [TAP_AW-1:0]       r_wp;
    logic [TAP_AW-1:0]       r_newest;
    logic [TAP_AW-1:0]       r_k;
    logic [PHW-1:0]          r_ph;
    logic                    r_drain;
    logic                    r_rd_vld;
    logic                    r_prod_vld;
    logic signed [AW-1:0]    r_acc;
    logic signed [PW-1:0]    r_prod;
    logic [DATA_WIDTH-1:0]   r_dl_q;
    logic [DATA_WIDTH-1:0]   r_coef_q;
    logic [DATA_WIDTH-1:0]   r_out_sample;
    logic                    r_out_valid;
    logic                    r_error;

    logic [DATA_WIDTH-1:0]   r_dline [TAPS];
    logic [DATA_WIDTH-1:0]   r_coef  [TAPS];

    logic                    w_dl_we;
    logic [TAP_AW-1:0]       w_dl_waddr;
    logic [DATA_WIDTH-1:0]   w_dl_wdata;
    logic [TAP_AW-1:0]       w_rd_addr;
    logic signed [PW-1:0]    w_dl_ext;
    logic signed [PW-1:0]    w_coef_ext;
    logic signed [PW-1:0]    w_prod;
    logic signed [AW-1:0]    w_prod_ext;
    logic signed [AW-1:0]    w_acc_next;
    logic signed [AW-1:0]    w_shift;
    logic                    w_pos_ovf;
    logic                    w_neg_ovf;
    logic [DATA_WIDTH-1:0]   w_sat_value;

    // The FIFO strobe is combinational so that data is valid in WAIT.
    assign rinc             = !rst && !init && en && !rempty && (r_state == S_IDLE);
    assign busy             = (r_state != S_IDLE);
    assign out_sample_valid = r_out_valid;
    assign out_sample       = r_out_sample;
    assign error_code       = r_error;

    assign w_dl_we    = (r_state == S_CLEAR) || (r_state == S_WAIT);
    assign w_dl_waddr = (r_state == S_CLEAR) ? r_clr_cnt : r_wp;
    assign w_dl_wdata = (r_state == S_CLEAR) ? '0 : rdata;
    assign w_rd_addr  = r_newest - r_k;

    // Sign-extend before multiplying so the low PW bits are the exact product.
    assign w_dl_ext   = {{DATA_WIDTH{r_dl_q[DATA_WIDTH-1]}}, r_dl_q};
    assign w_coef_ext = {{DATA_WIDTH{r_coef_q[DATA_WIDTH-1]}}, r_coef_q};
    assign w_prod     = w_dl_ext * w_coef_ext;
    assign w_prod_ext = {{TAP_AW{r_prod[PW-1]}}, r_prod};
    assign w_acc_next = r_prod_vld ? (r_acc + w_prod_ext) : r_acc;
    assign w_shift    = w_acc_next >>> (DATA_WIDTH - 1);
    assign w_pos_ovf  = (w_shift > SAT_MAX);
    assign w_neg_ovf  = (w_shift < SAT_MIN);
    assign w_sat_value = w_pos_ovf ? {1'b0, {(DATA_WIDTH-1){1'b1}}} :
                         w_neg_ovf ? {1'b1, {(DATA_WIDTH-1){1'b0}}} :
                                     w_shift[DATA_WIDTH-1:0];

    // Delay-line RAM: clear/sample writes, one synchronous read per cycle.
    always_ff @(posedge clk) begin
        if (w_dl_we) begin
            r_dline[w_dl_waddr] <= w_dl_wdata;
        end
        r_dl_q <= r_dline[w_rd_addr];
    end

    // Coefficient RAM: survives rst, writable only in init mode.
    always_ff @(posedge clk) begin
        if (!rst && init && coe_we) begin
            r_coef[coe_addr] <= coe_init;
        end
        r_coef_q <= r_coef[r_k];
    end

    // Product register sits between the RAM read and the accumulator.
    always_ff @(posedge clk) begin
        r_prod <= w_prod;
    end

    // Sequencer, MAC accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_CLEAR;
            r_clr_cnt    <= '0;
            r_wp         <= '0;
            r_newest     <= '0;
            r_k          <= '0;
            r_ph         <= '0;
            r_drain      <= 1'b0;
            r_rd_vld     <= 1'b0;
            r_prod_vld   <= 1'b0;
            r_acc        <= '0;
            r_out_sample <= '0;
            r_out_valid  <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            r_rd_vld    <= (r_state == S_CALC);
            r_prod_vld  <= r_rd_vld;
            r_acc       <= w_acc_next;
            if (init) begin
                r_state   <= S_CLEAR;
                r_clr_cnt <= '0;
                r_wp      <= '0;
                r_ph      <= '0;
                r_error   <= 1'b0;
            end else begin
                case (r_state)
                    S_CLEAR: begin
                        r_wp      <= '0;
                        r_ph      <= '0;
                        r_clr_cnt <= r_clr_cnt + TAP_AW'(1);
                        if (&r_clr_cnt) begin
                            r_state <= S_IDLE;
                        end
                    end
                    S_IDLE: begin
                        if (en && !rempty) begin
                            r_state <= S_WAIT;
                        end
                    end
                    S_WAIT: begin
                        r_newest <= r_wp;
                        r_wp     <= r_wp + TAP_AW'(1);
                        if (r_ph == PHW'(DECIM - 1)) begin
                            r_ph    <= '0;
                            r_acc   <= '0;
                            r_k     <= '0;
                            r_drain <= 1'b0;
                            r_state <= S_CALC;
                        end else begin
                            r_ph    <= r_ph + PHW'(1);
                            r_state <= S_IDLE;
                        end
                    end
                    S_CALC: begin
                        r_k <= r_k + TAP_AW'(1);
                        if (&r_k) begin
                            r_state <= S_DRAIN;
                        end
                    end
                    S_DRAIN: begin
                        if (r_drain) begin
                            // Final product lands this cycle, so take it from w_acc_next.
                            r_out_sample <= w_sat_value;
                            r_out_valid  <= 1'b1;
                            if (w_pos_ovf || w_neg_ovf) begin
                                r_error <= 1'b1;
                            end
                            r_state <= S_OUT;
                        end else begin
                            r_drain <= 1'b1;
                        end
                    end
                    S_OUT: begin
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_CLEAR;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/decim_fir_core.md
# decim_fir_core

Polyphase decimating FIR engine, the downsampling counterpart of the upsampler datapath in the sample-rate converter. It pulls input samples from an upstream FIFO through the same `rempty`/`rinc` read interface the upsampler uses. It stores them in a circular delay line and, after every DECIM accepted samples, runs a sequential TAPS-long multiply-accumulate against a loadable coefficient RAM. It emits one saturated output sample per DECIM inputs.

## Interface
- DATA_WIDTH, 32, sample and coefficient width, signed two's complement Q1.(DATA_WIDTH-1)
- DECIM, 4, decimation factor, ≥2, must divide TAPS
- TAPS, 32, filter length, power of two
- TAP_AW, 5, log2(TAPS), coefficient and delay-line address width
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  permits new FIFO reads; an in-flight computation always completes
- init  in  1  coefficient-load / flush mode
- rempty  in  1  upstream FIFO empty
- rdata  in  DATA_WIDTH  FIFO read data, valid the cycle after `rinc`
- rinc  out  1  FIFO read strobe, 1-cycle pulse
- coe_we  in  1  coefficient write strobe, honoured only while `init`=1
- coe_addr  in  TAP_AW  coefficient index k, where tap 0 multiplies the newest sample
- coe_init  in  DATA_WIDTH  coefficient write data
- out_sample_valid  out  1  1-cycle pulse, registered
- out_sample  out  DATA_WIDTH  decimated output, held until the next valid
- busy  out  1  high in any state other than IDLE
- error_code  out  1  sticky saturation flag

## Operation
- States: CLEAR, IDLE, WAIT, CALC, DRAIN, OUT.
- Delay line: TAPS×DATA_WIDTH synchronous RAM. Write pointer `wp` (TAP_AW bits) wraps modulo TAPS. Phase counter `ph` runs 0..DECIM-1.
- Coefficient RAM: TAPS×DATA_WIDTH synchronous RAM, written only by `coe_we` while `init`=1. It is not cleared by `rst`.
- CLEAR:
  - Writes zero to delay-line entry `clr_cnt` each cycle, for TAPS cycles.
  - Sets `wp`=0, `ph`=0.
  - Moves to IDLE when `clr_cnt` has wrapped and `init`=0; otherwise remains in CLEAR.
- IDLE: if `en` & !`init` & !`rempty`, pulse `rinc` and go to WAIT.
- WAIT:
  - Write `rdata` to delay-line entry `wp`; latch `newest`=`wp`; then `wp`++.
  - If `ph`=DECIM-1: set `ph`=0, clear `acc` and the tap counter `k`, and go to CALC.
  - Otherwise: `ph`++ and return to IDLE.
- CALC:
  - Each cycle issues reads delay-line[(`newest`−`k`) mod TAPS] and coef[`k`], then `k`++.
  - After TAPS cycles, go to DRAIN.
- Pipeline: RAM read (1 cycle) → registered product (1 cycle) → `acc` += product.
- DRAIN: 2 cycles to flush the pipeline, then go to OUT.
- OUT: register `out_sample`, pulse `out_sample_valid`, return to IDLE.
- Arithmetic:
  - Product is 2·DATA_WIDTH signed.
  - `acc` is 2·DATA_WIDTH+TAP_AW signed.
  - Result = `acc` >>> (DATA_WIDTH-1), truncated.
  - If the result lies outside the DATA_WIDTH signed range, saturate to 0x7FFFFFFF or 0x80000000 and set `error_code`.
- `init` rises in any state:
  - Go to CLEAR at the next edge and reset `clr_cnt`.
  - Any computation in flight is aborted with no `out_sample_valid`.
  - `error_code` is cleared.
  - `out_sample` is held.
- `rinc` is never asserted outside IDLE or while `init`=1. Once `rinc` has pulsed, the sample is always consumed, regardless of `en`.

## Timing
- Reset values: `rinc`=0, `out_sample_valid`=0, `out_sample`=0, `error_code`=0, `busy`=1.
- Reset state is CLEAR, so `busy` stays high for TAPS cycles after `rst` falls (given `init`=0).
- With `rinc` in cycle 0 for the DECIM-th sample of a group:
  - WAIT in cycle 1.
  - CALC in cycles 2..TAPS+1.
  - DRAIN in cycles TAPS+2..TAPS+3.
  - `out_sample_valid` high in cycle TAPS+4 only.
- Non-final samples of a group: `rinc` pulses can be no closer than every 2 cycles.
- Minimum input-to-output period: 2·DECIM + TAPS + 3 cycles.
- `rempty`=1 in IDLE: stall with no `rinc` and no state change.
- `rst` has priority over `init`, and `init` has priority over `en`.

## Test plan
- Reset: pulse `rst` with `init`=0 and `rempty`=0 → all outputs 0, `busy`=1 for 32 cycles, first `rinc` in cycle 33 after `rst` falls.
- DC gain:
  - Stimulus: all coefs 0x40000000, input constant 0x01000000.
  - First output 0x02000000, second 0x04000000; settles at 0x10000000 from the 8th output onward.
  - `error_code`=0 throughout.
- Impulse:
  - Stimulus: coef[k]=k·0x00100000, input 0x40000000 followed by zeros.
  - Outputs: 0x00180000, 0x00380000, 0x00580000, …, 0x00F80000, then 0.
- Saturation:
  - Stimulus: coefs 0x7FFFFFFF, input 0x7FFFFFFF.
  - First output 0x7FFFFFFF with `error_code`=1, which stays high.
  - Pulsing `init` clears it.
- Handshake/latency:
  - Stimulus: random `rempty` and `en` toggling.
  - `rinc` only in IDLE with `en`=1 and `rempty`=0.
  - `out_sample_valid` is a single pulse exactly 36 cycles after every 4th `rinc`.
  - Output values match a golden model.
- Abort: assert `init` during CALC → no `out_sample_valid`, `busy` for 32 cycles after `init` falls, next output equals a fresh-start result with a zeroed delay line.
